seq_booth_multiplier: RTL and testbench
=======================================

SEQ_BOOTH_MULTIPLIER -- requirements
Module: seq_booth_multiplier

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width; SHALL be even, >= 4, and a multiple of log2(RADIX).
REQ-002 SHALL have parameter RADIX, default 4, Booth radix; legal values 2, 4, 8, 16; R = log2(RADIX) bits recoded per step.
REQ-003 SHALL have ports, in this order:
- clk_i  in  1  clock
- rst_i  in  1  reset
- clk_en_i  in  1  global stall
- valid_i  in  1  operands valid
- ready_o  out  1  block can accept operands
- operand_A_i  in  DATA_WIDTH  multiplier
- operand_B_i  in  DATA_WIDTH  multiplicand
- signed_A_i  in  1  1 = A is two's complement, 0 = unsigned
- signed_B_i  in  1  1 = B is two's complement, 0 = unsigned
- result_o  out  2*DATA_WIDTH  product
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- busy_o  out  1  multiplication in progress
REQ-004 SHALL use one clock, clk_i; rst_i SHALL be synchronous and active-high.

Function
REQ-005 SHALL implement FSM states IDLE, MULTIPLY, DONE.
REQ-006 ready_o SHALL equal (state == IDLE) & clk_en_i; input transfer occurs at a rising edge with valid_i & ready_o.
REQ-007 On input transfer: SHALL capture both operands, extended to W = DATA_WIDTH + R bits (sign-extended if signed_x_i = 1, zero-extended otherwise); P = 0, L = 0, counter = 0; next state MULTIPLY.
REQ-008 In MULTIPLY: SHALL perform one radix-RADIX Booth step per enabled cycle.
- Step selects k*B, |k| <= RADIX/2, from {A[R-1:0], L}.
- Step adds k*B to P.
- Step arithmetic-shifts {P, A, L} right by R.
REQ-009 SHALL perform exactly N = DATA_WIDTH/R + 1 steps, then enter DONE.
REQ-010 Latency: valid_o SHALL rise N+1 enabled cycles after the accepting edge.
REQ-011 In DONE: valid_o = 1 and result_o = low 2*DATA_WIDTH bits of the exact product; both SHALL hold stable until valid_o & ready_i & clk_en_i, then the FSM returns to IDLE.
REQ-012 SHALL produce a correct product for all four signedness combinations, including -2^(DATA_WIDTH-1) operands and the all-ones unsigned maximum.
REQ-013 busy_o SHALL equal (state == MULTIPLY).
REQ-014 ready_o SHALL be 0 in MULTIPLY and DONE; valid_i SHALL be ignored there and SHALL not affect the computation in progress.
REQ-015 With clk_en_i = 0: SHALL freeze all state, counter, datapath and outputs; ready_i SHALL be ignored.
REQ-016 A new operation SHALL be acceptable in the cycle after the DONE->IDLE transfer; no back-to-back accept in the DONE cycle.
REQ-017 In IDLE and MULTIPLY, result_o SHALL hold the last delivered product, or 0 after reset.

Reset
REQ-018 rst_i = 1 at a rising edge SHALL force state IDLE, P/A/L/B/counter = 0, result_o = 0, valid_o = 0, busy_o = 0, regardless of clk_en_i.
REQ-019 Reset mid-MULTIPLY or in DONE SHALL discard the operation with no valid_o pulse; ready_o = clk_en_i from the first cycle after reset.

Configuration
REQ-020 Macro SEQ_BOOTH_MULTIPLIER_ZERO_BYPASS_EN:
- Defined: on input transfer with operand_A_i == 0 or operand_B_i == 0, SHALL go directly to DONE with result 0; valid_o rises 1 cycle after the accept.
- Undefined: zero operands SHALL take the full N+1-cycle latency; no compare logic present.

Verification (DATA_WIDTH = 8, RADIX = 4, N = 5, latency 6)
REQ-021 A = 0xFD (-3) signed, B = 0x05 signed -> valid_o 6 cycles after accept, result_o = 16'hFFF1.
REQ-022 A = 0xFF, B = 0xFF, both unsigned -> result_o = 16'hFE01; both signed -> 16'h0001; A signed, B unsigned -> 16'hFF01.
REQ-023 A = B = 0x80, both signed -> result_o = 16'h4000; both unsigned -> 16'h4000.
REQ-024 ready_i held 0 for 10 cycles after valid_o; clk_en_i = 0 for 3 cycles mid-MULTIPLY -> result stable and latency stretched by exactly 3; valid_i pulses during busy ignored.
REQ-025 rst_i asserted at step 3 -> next cycle valid_o = 0, busy_o = 0, result_o = 0, ready_o = 1; following op 0x07 x 0x09 signed -> 16'h003F.
REQ-026 A = 0x00, B = 0x7F -> result_o = 0 with valid_o after 1 cycle (macro defined) or after 6 cycles (macro undefined).

Source files
------------

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-RADIX Booth multiplier with valid/ready on both sides.
// Define SEQ_BOOTH_MULTIPLIER_ZERO_BYPASS_EN to skip the Booth steps for zero operands.
module seq_booth_multiplier #(
  parameter int DATA_WIDTH = 32,
  parameter int RADIX      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clk_en_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [DATA_WIDTH-1:0]   operand_A_i,
  input  logic [DATA_WIDTH-1:0]   operand_B_i,
  input  logic                    signed_A_i,
  input  logic                    signed_B_i,
  output logic [2*DATA_WIDTH-1:0] result_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o
);

  localparam int R  = $clog2(RADIX);
  localparam int W  = DATA_WIDTH + R;
  localparam int PW = W + R;
  localparam int N  = DATA_WIDTH / R + 1;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULTIPLY,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [PW-1:0]           r_p;
  logic [W-1:0]            r_a;
  logic [W-1:0]            r_b;
  logic                    r_l;
  logic [CW-1:0]           r_cnt;
  logic [2*DATA_WIDTH-1:0] r_res;

  logic signed [R:0]       w_k;
  logic signed [PW-1:0]    w_kx;
  logic signed [PW-1:0]    w_bx;
  logic signed [PW-1:0]    w_kb;
  logic [PW-1:0]           w_sum;
  logic [PW+W:0]           w_sh;
  logic [W-1:0]            w_a_ext;
  logic [W-1:0]            w_b_ext;
  logic                    w_last;
`ifdef SEQ_BOOTH_MULTIPLIER_ZERO_BYPASS_EN
  logic                    w_zero;
`endif

  always_comb begin
    // Booth digit from {A[R-1:0], L}: signed low group plus the borrow bit
    w_k = $signed({r_a[R-1], r_a[R-1:0]})
        + $signed({{R{1'b0}}, r_l});
    w_kx = {{(PW-R-1){w_k[R]}}, w_k};
    w_bx = {{R{r_b[W-1]}}, r_b};
    w_kb = w_kx * w_bx;
    w_sum = r_p + w_kb;
    w_sh = $signed({w_sum, r_a, r_l}) >>> R;
    w_last = (r_cnt == CW'(N - 1));
  end

  always_comb begin
    if (signed_A_i) begin
      w_a_ext = {{R{operand_A_i[DATA_WIDTH-1]}}, operand_A_i};
    end else begin
      w_a_ext = {{R{1'b0}}, operand_A_i};
    end
    if (signed_B_i) begin
      w_b_ext = {{R{operand_B_i[DATA_WIDTH-1]}}, operand_B_i};
    end else begin
      w_b_ext = {{R{1'b0}}, operand_B_i};
    end
  end

`ifdef SEQ_BOOTH_MULTIPLIER_ZERO_BYPASS_EN
  assign w_zero = (operand_A_i == '0) | (operand_B_i == '0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_l     <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (clk_en_i) begin
      unique case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_a   <= w_a_ext;
            r_b   <= w_b_ext;
            r_p   <= '0;
            r_l   <= 1'b0;
            r_cnt <= '0;
`ifdef SEQ_BOOTH_MULTIPLIER_ZERO_BYPASS_EN
            if (w_zero) begin
              r_res   <= '0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_MULTIPLY;
            end
`else
            r_state <= S_MULTIPLY;
`endif
          end
        end
        S_MULTIPLY: begin
          {r_p, r_a, r_l} <= w_sh;
          r_cnt <= r_cnt + CW'(1);
          // last step: the product sits in {P, A} of the shifted word
          if (w_last) begin
            r_res   <= w_sh[2*DATA_WIDTH:1];
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o  = (r_state == S_IDLE) & clk_en_i;
  assign busy_o   = (r_state == S_MULTIPLY);
  assign valid_o  = (r_state == S_DONE);
  assign result_o = r_res;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench for seq_booth_multiplier, DATA_WIDTH=8, RADIX=4.
// Expected products are queued at issue and popped when valid_o appears.
module tb_seq_booth_multiplier;

  localparam int DW  = 8;
  localparam int LAT = 6;
`ifdef SEQ_BOOTH_MULTIPLIER_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 6;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clk_en_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] operand_A_i;
  logic [DW-1:0] operand_B_i;
  logic          signed_A_i;
  logic          signed_B_i;
  logic [2*DW-1:0] result_o;
  logic          valid_o;
  logic          ready_i;
  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sa;
    logic        sb;
    logic [15:0] e;
  } vec_t;

  seq_booth_multiplier #(
    .DATA_WIDTH(DW),
    .RADIX(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clk_en_i(clk_en_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .operand_A_i(operand_A_i),
    .operand_B_i(operand_B_i),
    .signed_A_i(signed_A_i),
    .signed_B_i(signed_B_i),
    .result_o(result_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] model(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic sa,
    input logic sb
  );
    longint ea;
    longint eb;
    longint p;
    if (sa) ea = longint'($signed(a));
    else ea = longint'(a);
    if (sb) eb = longint'($signed(b));
    else eb = longint'(b);
    p = ea * eb;
    return p[15:0];
  endfunction

  task automatic send(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic sa,
    input logic sb,
    input logic [15:0] e
  );
    operand_A_i = a;
    operand_B_i = b;
    signed_A_i  = sa;
    signed_B_i  = sb;
    valid_i     = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (valid_o !== 1'b1 && lat < 100) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clk_en_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    operand_A_i = '0;
    operand_B_i = '0;
    signed_A_i = 1'b0;
    signed_B_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", valid_o);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", busy_o);
    end
    n_checks++;
    if (result_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_result: got %h want 0000", result_o);
    end
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_noen: got %b want 0", ready_o);
    end
    clk_en_i = 1'b1;
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_en: got %b want 1", ready_o);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_products();
    vec_t tv[10];
    vec_t v;
    logic [15:0] e;
    int lat;
    tv[0] = '{8'hFD, 8'h05, 1'b1, 1'b1, 16'hFFF1};
    tv[1] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01};
    tv[2] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 16'h0001};
    tv[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFF01};
    tv[4] = '{8'h80, 8'h80, 1'b1, 1'b1, 16'h4000};
    tv[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 16'h4000};
    tv[6] = '{8'h07, 8'h09, 1'b1, 1'b1, 16'h003F};
    tv[7] = '{8'h80, 8'hFF, 1'b1, 1'b0, 16'h8080};
    tv[8] = '{8'h7F, 8'h80, 1'b0, 1'b1, 16'hC080};
    tv[9] = '{8'h80, 8'h7F, 1'b0, 1'b0, 16'h3F80};
    for (int i = 0; i < 22; i++) begin
      if (i < 10) begin
        v = tv[i];
      end else begin
        v.a  = 8'($urandom_range(1, 255));
        v.b  = 8'($urandom_range(1, 255));
        v.sa = 1'($urandom_range(0, 1));
        v.sb = 1'($urandom_range(0, 1));
        v.e  = model(v.a, v.b, v.sa, v.sb);
      end
      send(v.a, v.b, v.sa, v.sb, v.e);
      wait_valid(1, lat);
      e = exp_q.pop_front();
      n_checks++;
      if (result_o !== e) begin
        n_fail++;
        $display("FAIL product_%0d: %h x %h s%b%b got %h want %h",
                 i, v.a, v.b, v.sa, v.sb, result_o, e);
      end
      n_checks++;
      if (lat != LAT) begin
        n_fail++;
        $display("FAIL latency_%0d: got %0d want %0d", i, lat, LAT);
      end
      consume();
    end
  endtask

  task automatic test_zero();
    vec_t tv[3];
    logic [15:0] e;
    int lat;
    tv[0] = '{8'h00, 8'h7F, 1'b1, 1'b1, 16'h0000};
    tv[1] = '{8'h5A, 8'h00, 1'b0, 1'b0, 16'h0000};
    tv[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      send(tv[i].a, tv[i].b, tv[i].sa, tv[i].sb, tv[i].e);
      wait_valid(1, lat);
      e = exp_q.pop_front();
      n_checks++;
      if (result_o !== e) begin
        n_fail++;
        $display("FAIL zero_%0d: got %h want %h", i, result_o, e);
      end
      n_checks++;
      if (lat != ZLAT) begin
        n_fail++;
        $display("FAIL zero_lat_%0d: got %0d want %0d", i, lat, ZLAT);
      end
      consume();
    end
  endtask

  task automatic test_stall();
    logic [15:0] e;
    int lat;
    bit bad;
    // IDLE with clk_en low: no accept
    clk_en_i = 1'b0;
    operand_A_i = 8'h11;
    operand_B_i = 8'h22;
    valid_i = 1'b1;
    #1;
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_idle_ready: got %b want 0", ready_o);
    end
    @(posedge clk_i);
    #1;
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_accept: busy %b want 0", busy_o);
    end
    valid_i = 1'b0;
    clk_en_i = 1'b1;
    send(8'h9C, 8'h3B, 1'b1, 1'b0, model(8'h9C, 8'h3B, 1'b1, 1'b0));
    lat = 1;
    @(posedge clk_i);
    #1;
    lat++;
    clk_en_i = 1'b0;
    operand_A_i = 8'h55;
    operand_B_i = 8'hAA;
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      lat++;
      n_checks++;
      if ({busy_o, valid_o} !== 2'b10) begin
        n_fail++;
        $display("FAIL stall_frozen_%0d: busy/valid %b want 10",
                 i, {busy_o, valid_o});
      end
    end
    clk_en_i = 1'b1;
    @(posedge clk_i);
    #1;
    lat++;
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready: got %b want 0", ready_o);
    end
    valid_i = 1'b0;
    wait_valid(lat, lat);
    e = exp_q.pop_front();
    n_checks++;
    if (lat != LAT + 3) begin
      n_fail++;
      $display("FAIL stall_lat: got %0d want %0d", lat, LAT + 3);
    end
    n_checks++;
    if (result_o !== e) begin
      n_fail++;
      $display("FAIL stall_result: got %h want %h", result_o, e);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1;
      if (valid_o !== 1'b1 || result_o !== e || ready_o !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL done_hold: valid %b result %h want 1 %h",
               valid_o, result_o, e);
    end
    clk_en_i = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if (valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL done_noen_hold: valid %b want 1", valid_o);
    end
    clk_en_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    n_checks++;
    if ({valid_o, ready_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL done_release: valid/ready %b want 01",
               {valid_o, ready_o});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    logic [15:0] prev;
    int lat;
    send(8'hE7, 8'h13, 1'b1, 1'b1, model(8'hE7, 8'h13, 1'b1, 1'b1));
    wait_valid(1, lat);
    prev = exp_q.pop_front();
    n_checks++;
    if (result_o !== prev) begin
      n_fail++;
      $display("FAIL b2b_first: got %h want %h", result_o, prev);
    end
    ready_i = 1'b1;
    operand_A_i = 8'hC3;
    operand_B_i = 8'h5D;
    signed_A_i = 1'b0;
    signed_B_i = 1'b1;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    n_checks++;
    if ({valid_o, busy_o, ready_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b_no_accept_in_done: v/b/r %b want 001",
               {valid_o, busy_o, ready_o});
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    exp_q.push_back(model(8'hC3, 8'h5D, 1'b0, 1'b1));
    n_checks++;
    if (busy_o !== 1'b1 || result_o !== prev) begin
      n_fail++;
      $display("FAIL b2b_hold_prev: busy %b result %h want 1 %h",
               busy_o, result_o, prev);
    end
    wait_valid(1, lat);
    e = exp_q.pop_front();
    n_checks++;
    if (result_o !== e || lat != LAT) begin
      n_fail++;
      $display("FAIL b2b_second: got %h lat %0d want %h lat %0d",
               result_o, lat, e, LAT);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    int lat;
    bit bad;
    send(8'h33, 8'h44, 1'b0, 1'b0, model(8'h33, 8'h44, 1'b0, 1'b0));
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    n_checks++;
    if ({valid_o, busy_o, ready_o} !== 3'b001 || result_o !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid: v/b/r %b result %h want 001 0000",
               {valid_o, busy_o, ready_o}, result_o);
    end
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i);
      #1;
      if (valid_o !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL rst_mid_no_pulse: valid rose want 0");
    end
    send(8'h07, 8'h09, 1'b1, 1'b1, 16'h003F);
    wait_valid(1, lat);
    e = exp_q.pop_front();
    n_checks++;
    if (result_o !== e || lat != LAT) begin
      n_fail++;
      $display("FAIL rst_after_op: got %h lat %0d want %h lat %0d",
               result_o, lat, e, LAT);
    end
    send(8'h12, 8'h34, 1'b0, 1'b0, model(8'h12, 8'h34, 1'b0, 1'b0));
    wait_valid(1, lat);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    n_checks++;
    if ({valid_o, ready_o} !== 2'b01 || result_o !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_done: v/r %b result %h want 01 0000",
               {valid_o, ready_o}, result_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_products();
    test_zero();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
